// File: rtl/bidir_pio_irq.sv
// Bidirectional parallel I/O port on a lightweight Avalon-MM slave: atomic set/clear, 2-flop input sync,
// optional rising-edge capture with maskable level irq (built when BIDIR_PIO_EDGE_IRQ_EN is defined).
module bidir_pio_irq #(
   parameter int unsigned      WIDTH     = 16,
   parameter logic [WIDTH-1:0] RESET_OUT = '0,
   parameter logic [WIDTH-1:0] RESET_DIR = '0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   inout  wire  [WIDTH-1:0] bidir_port,
   output logic             irq
);
   localparam logic [2:0] ADDR_DATA   = 3'd0;
   localparam logic [2:0] ADDR_DIR    = 3'd1;
   localparam logic [2:0] ADDR_MASK   = 3'd2;
   localparam logic [2:0] ADDR_EDGE   = 3'd3;
   localparam logic [2:0] ADDR_OUTSET = 3'd4;
   localparam logic [2:0] ADDR_OUTCLR = 3'd5;

   logic             wr_c;
   logic [WIDTH-1:0] wdata;
   logic [WIDTH-1:0] data_out_q, data_out_d;
   logic [WIDTH-1:0] data_dir_q, data_dir_d;
   logic [WIDTH-1:0] s1_q, s2_q;
   logic [31:0]      readdata_q, readdata_d;
   logic             unused_wdata;

   assign wr_c         = chipselect & ~write_n;
   assign wdata        = writedata[WIDTH-1:0];
   assign unused_wdata = ^writedata;
   assign readdata     = readdata_q;

   // Per-pin tri-state driver
   for (genvar i = 0; i < WIDTH; i++) begin : g_pin
      assign bidir_port[i] = data_dir_q[i] ? data_out_q[i] : 1'bz;
   end

`ifdef BIDIR_PIO_EDGE_IRQ_EN
   logic [WIDTH-1:0] s3_q;
   logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
   logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
   logic [WIDTH-1:0] rise_c;
   logic [1:0]       arm_cnt_q, arm_cnt_d;
   logic             armed_c;

   assign rise_c  = s2_q & ~s3_q;
   assign armed_c = (arm_cnt_q == 2'd3);
   assign irq     = |(edge_cap_q & irq_mask_q);

   // Edge capture (set beats write-1-to-clear), mask and post-reset arming counter
   always_comb begin
      irq_mask_d = irq_mask_q;
      edge_cap_d = edge_cap_q;
      arm_cnt_d  = armed_c ? arm_cnt_q : arm_cnt_q + 2'd1;
      if (wr_c && address == ADDR_MASK) irq_mask_d = wdata;
      if (wr_c && address == ADDR_EDGE) edge_cap_d = edge_cap_q & ~wdata;
      if (armed_c) edge_cap_d = edge_cap_d | rise_c;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s3_q       <= '0;
         irq_mask_q <= '0;
         edge_cap_q <= '0;
         arm_cnt_q  <= 2'd0;
      end else begin
         s3_q       <= s2_q;
         irq_mask_q <= irq_mask_d;
         edge_cap_q <= edge_cap_d;
         arm_cnt_q  <= arm_cnt_d;
      end
   end
`else
   assign irq = 1'b0;
`endif

   // Output data / direction register updates
   always_comb begin
      data_out_d = data_out_q;
      data_dir_d = data_dir_q;
      if (wr_c) begin
         case (address)
            ADDR_DATA:   data_out_d = wdata;
            ADDR_DIR:    data_dir_d = wdata;
            ADDR_OUTSET: data_out_d = data_out_q | wdata;
            ADDR_OUTCLR: data_out_d = data_out_q & ~wdata;
            default:     data_out_d = data_out_q;
         endcase
      end
   end

   // Read mux, sampled every cycle regardless of chipselect
   always_comb begin
      readdata_d = 32'h0;
      case (address)
         ADDR_DATA:   readdata_d = 32'(s2_q);
         ADDR_DIR:    readdata_d = 32'(data_dir_q);
`ifdef BIDIR_PIO_EDGE_IRQ_EN
         ADDR_MASK:   readdata_d = 32'(irq_mask_q);
         ADDR_EDGE:   readdata_d = 32'(edge_cap_q);
`endif
         ADDR_OUTSET: readdata_d = 32'(data_out_q);
         ADDR_OUTCLR: readdata_d = 32'(data_out_q);
         default:     readdata_d = 32'h0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_out_q <= RESET_OUT;
         data_dir_q <= RESET_DIR;
         s1_q       <= '0;
         s2_q       <= '0;
         readdata_q <= 32'h0;
      end else begin
         data_out_q <= data_out_d;
         data_dir_q <= data_dir_d;
         s1_q       <= bidir_port;
         s2_q       <= s1_q;
         readdata_q <= readdata_d;
      end
   end

endmodule

// File: doc/bidir_pio_irq.md
# bidir_pio_irq

Parametrised bidirectional parallel I/O port on the HPS lightweight Avalon-MM bus. It is the next-generation successor of the fixed 16-bit LCD port:
- configurable width and reset values;
- atomic bit set/clear registers;
- two-flop input synchronisation;
- rising-edge capture with a maskable level interrupt.

It sits between the bus fabric and character-LCD / GPIO header pins.

## Interface
- `WIDTH`, 16, port width in bits (1..32).
- `RESET_OUT`, 0, reset value of the output data register (`WIDTH` bits).
- `RESET_DIR`, 0, reset value of the direction register; 1 = output.
- `clk` input 1: single clock, all logic rising-edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `address` input 3: register select.
- `chipselect` input 1: slave select.
- `write_n` input 1: active-low write strobe.
- `writedata` input 32: write data; bits above `WIDTH` ignored.
- `readdata` output 32: registered read data, zero-extended.
- `bidir_port` inout `WIDTH`: pins; bit i driven with `data_out[i]` when `data_dir[i]`=1, else Z.
- `irq` output 1: level interrupt, active-high.

## Operation
- Write strobe `wr` = `chipselect` & ~`write_n`. Registers by address:
  - 0 DATA: read returns synchronised pin state; write loads `data_out`.
  - 1 DIR: read/write `data_dir`.
  - 2 IRQMASK: read/write `irq_mask`.
  - 3 EDGE: read `edge_cap`; write-1-to-clear.
  - 4 OUTSET: write `data_out` |= wdata; read returns `data_out`.
  - 5 OUTCLR: write `data_out` &= ~wdata; read returns `data_out`.
  - 6, 7: reads return 0; writes ignored.
- Input path:
  - `s1` <= pins, `s2` <= `s1`, `s3` <= `s2`.
  - `rise` = `s2` & ~`s3`.
- Edge capture:
  - `edge_cap[i]` sets when `rise[i]` and `armed`.
  - `edge_cap[i]` clears on an EDGE write with bit i = 1.
  - Set and clear on the same bit in the same cycle: set wins.
- Arm counter:
  - A 2-bit counter counts from 0 after reset release; `armed` = counter==3, saturating.
  - Suppresses spurious captures from pins held high through reset.
- `irq` = |(`edge_cap` & `irq_mask`), combinational from registers; no pin-to-irq combinational path.
- Pins configured as outputs still feed the input path; their own driven edges are captured.

## Timing
- Reset values:
  - `readdata`=0, `data_out`=`RESET_OUT`, `data_dir`=`RESET_DIR`.
  - `irq_mask`=0, `edge_cap`=0, `s1`/`s2`/`s3`=0, counter=0, `irq`=0.
- Reads:
  - `readdata` updates every cycle from the current `address`, regardless of `chipselect`.
  - Latency is 1 cycle (zero wait states).
- Writes take effect at the clock edge where `wr` is sampled. A pin drive change is visible after that edge.
- Pin sampled into `s1` at edge k:
  - `s2` at k+1;
  - DATA read value in `readdata` at k+2;
  - `edge_cap` set at k+2, provided `armed`;
  - `irq` high after k+2 if masked in.
- `armed` becomes 1 at the 3rd rising edge after `reset_n` deasserts.
- `reset_n` assertion mid-operation immediately (asynchronously) returns all state to reset values, tri-states pins per `RESET_DIR`, and drops `irq`.

## Configuration
- Macro `BIDIR_PIO_EDGE_IRQ_EN`.
- Defined: edge capture, IRQMASK, arm counter and `irq` are built as above.
- Undefined:
  - `edge_cap`, `irq_mask`, `s3` and the arm counter are not built;
  - addresses 2 and 3 read 0 and ignore writes;
  - `irq` is tied 0;
  - DATA/DIR/OUTSET/OUTCLR behaviour and timing are unchanged.

## Test plan
- Reset and direction:
  - Stimulus: `WIDTH`=16, `RESET_DIR`=0; after reset, write DIR=0x00FF, DATA=0xA5C3.
  - Required: `bidir_port` low byte = 0xC3, high byte Z; DIR read returns 0x000000FF one cycle after address=1.
- Set/clear:
  - Stimulus: DATA=0x00F0, OUTSET 0x000F, OUTCLR 0x0030.
  - Required: reads of address 4 return 0x000000FF, then 0x000000CF; untouched bits stay stable.
- Synchroniser latency:
  - Stimulus: DIR=0, external drive of 0x1234 sampled at edge k, address=0 held.
  - Required: `readdata`=0x00001234 at edge k+2, not earlier.
- Edge and irq:
  - Stimulus: IRQMASK=0x0004; pin 2 rises, then pin 3 rises.
  - Required: EDGE reads 0x0000000C; `irq`=1 from edge k+2 of pin 2's rise; write EDGE=0x0004 → `irq`=0, EDGE=0x00000008.
- Simultaneous set/clear and reset arming:
  - Stimulus A: rise on pin 0 coincides with an EDGE=0x0001 write. Required: bit 0 remains 1.
  - Stimulus B: pin 0 held high through reset. Required: EDGE stays 0.
- Macro off:
  - Stimulus: build without `BIDIR_PIO_EDGE_IRQ_EN`; toggle pins; write 0xFFFF to addresses 2 and 3.
  - Required: reads of 2 and 3 return 0, and `irq` stays 0.
